// File: rtl/harris_pkg.sv
// Shared definitions for the Harris frame sequencer: FSM state encoding and fixed timing constants.
package harris_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    // Cycles the detector is held in reset at the start of every frame.
    localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/seq_raster_counter.sv
// Raster position counter for one frame: x wraps at IMG_W-1 and advances y; flags the final pixel.
module seq_raster_counter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 464
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic step_i,
    output logic last_pixel_o
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clear_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (step_i) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/harris_frame_sequencer.sv
// Frame-level sequencer: paces one raster frame from a valid/ready source into the Harris detector,
// drains its pipeline and reports completion, abort, source-stall errors and the corner count.
module harris_frame_sequencer
    import harris_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 464,
    parameter int DRAIN_CYCLES = 8,
    parameter int STALL_MAX    = 1024,
    parameter int CNT_W        = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_pixel,
    output logic                  src_ready,
    output logic                  det_rst_n,
    output logic                  det_valid,
    output logic [DATA_WIDTH-1:0] det_pixel,
    input  logic                  det_out_valid,
    input  logic                  det_corner,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_aborted,
    output logic                  stall_err,
    output logic [CNT_W-1:0]      corner_count,
    output logic [2:0]            dbg_state
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

    seq_state_e            state_q, state_d;
    logic [CW-1:0]         clr_q;
    logic [DW-1:0]         drain_q;
    logic [SW-1:0]         stall_q;
    logic [CNT_W-1:0]      corner_q, corner_d;
    logic                  stall_err_q, stall_err_d;
    logic                  det_valid_q, frame_done_q, frame_aborted_q;
    logic [DATA_WIDTH-1:0] det_pixel_q;

    logic accept, last_pixel, start_ok, stall_hit, counting, abort_hit;

    // Source handshake: a pixel transfers on any cycle with src_valid && src_ready; src_ready
    // depends only on the FSM state, so it never combinationally follows src_valid.
    assign accept    = src_valid && (state_q == STREAM);
    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign abort_hit = (state_q != IDLE) && abort;
    assign stall_hit = (state_q == STREAM) && !src_valid && (stall_q == SW'(STALL_MAX - 1));
    assign counting  = state_q inside {CLEAR, STREAM, DRAIN};

    seq_raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q == CLEAR),
        .step_i       (accept),
        .last_pixel_o (last_pixel)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = CLEAR;
            CLEAR:   if (clr_q == CW'(CLEAR_CYCLES - 1)) state_d = STREAM;
            STREAM:  if (accept && last_pixel) state_d = DRAIN;
                     else if (stall_hit) state_d = IDLE;
            DRAIN:   if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every other transition, including the final pixel and the stall timeout.
        if (abort_hit) state_d = IDLE;
    end

    always_comb begin
        corner_d = corner_q;
        if (start_ok) begin
            corner_d = '0;
        end else if (counting && det_out_valid && det_corner && (corner_q != '1)) begin
            corner_d = corner_q + CNT_W'(1);
        end
        stall_err_d = stall_err_q;
        if (start_ok) stall_err_d = 1'b0;
        else if (stall_hit && !abort_hit) stall_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            clr_q           <= '0;
            drain_q         <= '0;
            stall_q         <= '0;
            corner_q        <= '0;
            stall_err_q     <= 1'b0;
            det_valid_q     <= 1'b0;
            det_pixel_q     <= '0;
            frame_done_q    <= 1'b0;
            frame_aborted_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_q           <= (state_q == CLEAR) ? clr_q + CW'(1) : '0;
            drain_q         <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;
            stall_q         <= ((state_q == STREAM) && !src_valid) ? stall_q + SW'(1) : '0;
            corner_q        <= corner_d;
            stall_err_q     <= stall_err_d;
            det_valid_q     <= accept && !abort;
            if (accept) det_pixel_q <= src_pixel;
            frame_done_q    <= (state_q == DONE) && !abort;
            frame_aborted_q <= abort_hit || stall_hit;
        end
    end

    assign src_ready     = (state_q == STREAM);
    assign det_rst_n     = (state_q != CLEAR);
    assign det_valid     = det_valid_q;
    assign det_pixel     = det_pixel_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign frame_aborted = frame_aborted_q;
    assign stall_err     = stall_err_q;
    assign corner_count  = corner_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Bench for harris_frame_sequencer on a 4x3 frame: table-driven and random frames against a
// pixel-queue scoreboard and frame-level timing rules, plus hand-written corner-case sequences.
module tb_harris_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NPIX  = W * H;
  localparam int DRAIN = 8;
  localparam int STALL = 16;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, src_valid, det_out_valid, det_corner;
  logic [7:0] src_pixel;
  logic       src_ready, det_rst_n, det_valid, busy, frame_done, frame_aborted, stall_err;
  logic [7:0] det_pixel;
  logic [19:0] corner_count;
  logic [2:0] dbg_state;
  logic       s_src_ready, s_det_rst_n, s_det_valid, s_busy, s_frame_done, s_frame_aborted, s_stall_err;
  logic [7:0] s_det_pixel;
  logic [1:0] s_corner_count;
  logic [2:0] s_dbg_state;

  harris_frame_sequencer #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .DRAIN_CYCLES(DRAIN),
                           .STALL_MAX(STALL), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src_valid(src_valid),
    .src_pixel(src_pixel), .src_ready(src_ready), .det_rst_n(det_rst_n), .det_valid(det_valid),
    .det_pixel(det_pixel), .det_out_valid(det_out_valid), .det_corner(det_corner), .busy(busy),
    .frame_done(frame_done), .frame_aborted(frame_aborted), .stall_err(stall_err),
    .corner_count(corner_count), .dbg_state(dbg_state));

  harris_frame_sequencer #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .DRAIN_CYCLES(DRAIN),
                           .STALL_MAX(STALL), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src_valid(src_valid),
    .src_pixel(src_pixel), .src_ready(s_src_ready), .det_rst_n(s_det_rst_n), .det_valid(s_det_valid),
    .det_pixel(s_det_pixel), .det_out_valid(det_out_valid), .det_corner(det_corner), .busy(s_busy),
    .frame_done(s_frame_done), .frame_aborted(s_frame_aborted), .stall_err(s_stall_err),
    .corner_count(s_corner_count), .dbg_state(s_dbg_state));

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // scoreboard
  logic [7:0] exp_q[$];
  int dv_count = 0;
  int done_seen = 0;
  int aborted_seen = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (src_valid && src_ready) begin
        exp_q.push_back(src_pixel);
        last_acc_cyc = cyc + 1;
      end
      if (det_valid) begin
        dv_count++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL det_pixel_unexpected: got %0d with no pixel pending", det_pixel);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (det_pixel !== e) begin
            fails++;
            $display("FAIL det_pixel_order: got %0d expected %0d", det_pixel, e);
          end
        end
      end
      if (frame_done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (frame_aborted) aborted_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int pct;
    int hits;
    int abort_after;
    int start_mid;
    int exp_dv;
    int exp_done;
    int exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v);
    int acc, tries, lows, c0, done0, ab0, dv0, sat;
    done0 = done_seen;
    ab0   = aborted_seen;
    dv0   = dv_count;
    tick();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clear_det_rst_n", det_rst_n, 0);
    check("clear_src_ready", src_ready, 0);
    check("clear_busy", busy, 1);
    acc = 0; tries = 0; lows = 0;
    while (acc < NPIX && !(v.abort_after >= 0 && acc == v.abort_after) && tries < 400) begin
      src_valid     = (lows >= 8) || ($urandom_range(99, 0) < v.pct);
      src_pixel     = 8'($urandom);
      start         = (v.start_mid != 0) && (acc == 6);
      det_out_valid = src_valid && src_ready && (acc < v.hits);
      det_corner    = det_out_valid;
      lows          = src_valid ? 0 : lows + 1;
      if (src_valid && src_ready) acc++;
      tick();
      tries++;
    end
    src_valid = 1'b0; start = 1'b0; det_out_valid = 1'b0; det_corner = 1'b0;
    if (tries >= 400) check("stream_timeout", tries, 0);
    if (v.abort_after >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_pulse", frame_aborted, 1);
      check("abort_busy", busy, 0);
      check("abort_src_ready", src_ready, 0);
      check("abort_det_valid", det_valid, 0);
      tick();
      check("abort_pulse_end", frame_aborted, 0);
    end else begin
      for (int k = 0; k < 60 && done_seen == done0; k++) tick();
      tick();
    end
    check("det_valid_count", dv_count - dv0, v.exp_dv);
    check("pixels_pending", exp_q.size(), 0);
    check("frame_done_count", done_seen - done0, v.exp_done);
    check("frame_aborted_count", aborted_seen - ab0, (v.exp_done != 0) ? 0 : 1);
    if (v.exp_done != 0) begin
      check("done_after_last_accept", done_cyc - last_acc_cyc, 1 + DRAIN);
      if (v.pct >= 100 && v.start_mid == 0)
        check("done_after_start", done_cyc - c0, 2 + NPIX + 1 + DRAIN + 1);
    end
    sat = (v.exp_cnt > 3) ? 3 : v.exp_cnt;
    check("corner_count", corner_count, v.exp_cnt);
    check("corner_count_sat", s_corner_count, sat);
    check("stall_err_clean", stall_err, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cnt;
    vec_t rv;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_pixel = '0;
    det_out_valid = 1'b0; det_corner = 1'b0;
    vecs[0] = '{pct: 100, hits: 3, abort_after: -1, start_mid: 0, exp_dv: 12, exp_done: 1, exp_cnt: 3};
    vecs[1] = '{pct: 50,  hits: 0, abort_after: -1, start_mid: 1, exp_dv: 12, exp_done: 1, exp_cnt: 0};
    vecs[2] = '{pct: 70,  hits: 5, abort_after: -1, start_mid: 0, exp_dv: 12, exp_done: 1, exp_cnt: 5};
    vecs[3] = '{pct: 100, hits: 2, abort_after: 5,  start_mid: 0, exp_dv: 5,  exp_done: 0, exp_cnt: 2};
    vecs[4] = '{pct: 60,  hits: 4, abort_after: -1, start_mid: 0, exp_dv: 12, exp_done: 1, exp_cnt: 4};

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_det_rst_n", det_rst_n, 1);
    check("rst_src_ready", src_ready, 0);
    check("rst_det_valid", det_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_aborted", frame_aborted, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_corner_count", corner_count, 0);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv.pct = int'($urandom_range(100, 40));
      rv.hits = int'($urandom_range(NPIX, 0));
      rv.abort_after = -1;
      rv.start_mid = 0;
      rv.exp_dv = NPIX;
      rv.exp_done = 1;
      rv.exp_cnt = rv.hits;
      run_frame(rv);
    end
    last_cnt = rv.exp_cnt;

    // corner hits while idle must not move the held count
    det_out_valid = 1'b1; det_corner = 1'b1;
    repeat (3) tick();
    det_out_valid = 1'b0; det_corner = 1'b0;
    check("idle_hits_ignored", corner_count, last_cnt);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_det_rst_n", det_rst_n, 1);
    check("start_abort_no_pulse", frame_aborted, 0);
    tick();

    // stall: 15 idle cycles tolerated, an accept resets the run, 16 idle cycles abort
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("stall_stream_ready", src_ready, 1);
    repeat (STALL - 1) tick();
    check("stall_15_busy", busy, 1);
    check("stall_15_err", stall_err, 0);
    src_valid = 1'b1; src_pixel = 8'hA5;
    tick();
    src_valid = 1'b0;
    repeat (STALL - 1) tick();
    check("stall_reset_busy", busy, 1);
    tick();
    check("stall_err_set", stall_err, 1);
    check("stall_aborted_pulse", frame_aborted, 1);
    check("stall_busy", busy, 0);
    tick();
    check("stall_pulse_end", frame_aborted, 0);
    check("stall_err_sticky", stall_err, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("stall_err_cleared", stall_err, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("restart_abort_busy", busy, 0);
    tick();

    // asynchronous reset in the middle of a frame
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    repeat (3) begin
      src_valid = 1'b1; src_pixel = 8'($urandom);
      det_out_valid = 1'b1; det_corner = 1'b1;
      tick();
    end
    src_valid = 1'b0; det_out_valid = 1'b0; det_corner = 1'b0;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_det_rst_n", det_rst_n, 1);
    check("mid_rst_src_ready", src_ready, 0);
    check("mid_rst_det_valid", det_valid, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_frame_aborted", frame_aborted, 0);
    check("mid_rst_stall_err", stall_err, 0);
    check("mid_rst_corner_count", corner_count, 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    tick();

    // a clean frame after reset still works end to end
    run_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
